// File: rtl/bus_simple_arbiter_pkg.sv
// Shared bus widths and arbiter state encoding for the bus_simple arbiter.
package bus_simple_arbiter_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ADDR  = 2'd1,
        ARB_RDATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_simple_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Built as a double-width rotate plus a priority encoder.
module bus_simple_arbiter_rr_pick #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    localparam logic [IW:0] N_EXT = (IW + 1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_EXT) sum = sum - N_EXT;
        gnt_idx = sum[IW-1:0];
        gnt_any = |req;
    end

endmodule

// File: rtl/bus_simple_arbiter.sv
// N-master round-robin arbiter in front of the single bus_simple master port.
// A grant covers one whole transaction: a write until accepted, a read until
// m_rvalid arrives or the read-response timeout fires.
module bus_simple_arbiter
    import bus_simple_arbiter_pkg::*;
#(
    parameter int          NUM_MASTERS = 2,
    parameter int          RD_TIMEOUT  = 256,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF,
    localparam int         IW = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        s_valid,
    input  logic [NUM_MASTERS-1:0]        s_write,
    input  logic [NUM_MASTERS*BUS_AW-1:0] s_addr,
    input  logic [NUM_MASTERS*BUS_DW-1:0] s_wdata,
    input  logic [NUM_MASTERS*BUS_SW-1:0] s_wstrb,
    output logic [NUM_MASTERS-1:0]        s_ready,
    output logic [NUM_MASTERS-1:0]        s_rvalid,
    output logic [BUS_DW-1:0]             s_rdata,
    output logic                          m_valid,
    output logic                          m_write,
    output logic [BUS_AW-1:0]             m_addr,
    output logic [BUS_DW-1:0]             m_wdata,
    output logic [BUS_SW-1:0]             m_wstrb,
    input  logic                          m_ready,
    input  logic                          m_rvalid,
    input  logic [BUS_DW-1:0]             m_rdata,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          rd_timeout
);

    localparam int                   CW       = $clog2(RD_TIMEOUT);
    localparam logic [CW-1:0]        CNT_LAST = CW'(RD_TIMEOUT - 1);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_MASTERS - 1);

    arb_state_t             state;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          next_ptr;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic [CW-1:0]          cnt;
    logic                   g_valid;
    logic                   g_write;
    logic [BUS_AW-1:0]      g_addr;
    logic [BUS_DW-1:0]      g_wdata;
    logic [BUS_SW-1:0]      g_wstrb;
    logic [NUM_MASTERS-1:0] g_onehot;
    logic                   rd_last;

    bus_simple_arbiter_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req     (s_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign g_onehot = NUM_MASTERS'(1) << grant_id;
    assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    assign rd_last  = (cnt == CNT_LAST);
    assign busy     = (state != ARB_IDLE);

    // Select the request fields of the currently granted master.
    always_comb begin
        g_valid = 1'b0;
        g_write = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_id == IW'(i)) begin
                g_valid = s_valid[i];
                g_write = s_write[i];
                g_addr  = s_addr[BUS_AW*i +: BUS_AW];
                g_wdata = s_wdata[BUS_DW*i +: BUS_DW];
                g_wstrb = s_wstrb[BUS_SW*i +: BUS_SW];
            end
        end
    end

    // Drive the bus and the per-master handshakes; everything is silenced while rst is high.
    always_comb begin
        m_valid    = 1'b0;
        m_write    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_wstrb    = '0;
        s_ready    = '0;
        s_rvalid   = '0;
        s_rdata    = '0;
        rd_timeout = 1'b0;
        if (!rst) begin
            case (state)
                ARB_ADDR: begin
                    m_valid = g_valid;
                    m_write = g_write;
                    m_addr  = g_addr;
                    m_wdata = g_wdata;
                    m_wstrb = g_wstrb;
                    if (g_valid && m_ready) begin
                        s_ready = g_onehot;
                        if (!g_write && m_rvalid) begin
                            s_rvalid = g_onehot;
                            s_rdata  = m_rdata;
                        end
                    end
                end
                ARB_RDATA: begin
                    if (m_rvalid) begin
                        s_rvalid = g_onehot;
                        s_rdata  = m_rdata;
                    end else if (rd_last) begin
                        s_rvalid   = g_onehot;
                        s_rdata    = ERR_RDATA;
                        rd_timeout = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arbitration FSM: pick in IDLE, hold the grant through ADDR and RDATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (!g_valid) begin
                        // Requester withdrew before the handshake: no turn consumed.
                        state <= ARB_IDLE;
                    end else if (m_ready) begin
                        if (g_write || m_rvalid) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= next_ptr;
                        end else begin
                            state <= ARB_RDATA;
                            cnt   <= '0;
                        end
                    end
                end
                ARB_RDATA: begin
                    if (m_rvalid || rd_last) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= next_ptr;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_simple_arbiter.sv
// Directed, table-driven bench for bus_simple_arbiter with two masters and a
// short read timeout. Each vector is one clock cycle of inputs plus the
// outputs expected during that cycle.
module tb_bus_simple_arbiter;

    localparam logic [31:0] A0  = 32'h4000_0000;
    localparam logic [31:0] A1  = 32'h4000_0010;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s_valid = '0;
    logic [1:0]  s_write = '0;
    logic [63:0] s_addr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_ready;
    logic [1:0]  s_rvalid;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [0:0]  grant_id;
    logic        busy;
    logic        rd_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        rst;
        logic [1:0]  sv;
        logic [1:0]  sw;
        logic        mr;
        logic        mrv;
        logic [31:0] mrd;
        logic        mv;
        logic        mw;
        logic [31:0] ma;
        logic [1:0]  srdy;
        logic [1:0]  srv;
        logic [31:0] srd;
        logic        gid;
        logic        bsy;
        logic        tmo;
    } vec_t;

    vec_t tbl[$];

    assign s_addr  = {A1, A0};
    assign s_wdata = {32'h1111_2222, 32'hDEAD_BEEF};
    assign s_wstrb = {4'h3, 4'hF};

    bus_simple_arbiter #(
        .NUM_MASTERS (2),
        .RD_TIMEOUT  (16),
        .ERR_RDATA   (ERR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_write    (s_write),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .m_valid    (m_valid),
        .m_write    (m_write),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_ready    (m_ready),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .rd_timeout (rd_timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [1:0] sv, input logic [1:0] sw,
                                input logic mr, input logic mrv, input logic [31:0] mrd,
                                input logic mv, input logic mw, input logic [31:0] ma,
                                input logic [1:0] srdy, input logic [1:0] srv, input logic [31:0] srd,
                                input logic gid, input logic bsy, input logic tmo);
        vec_t v;
        v.rst = r;   v.sv = sv;    v.sw = sw;   v.mr = mr;   v.mrv = mrv; v.mrd = mrd;
        v.mv = mv;   v.mw = mw;    v.ma = ma;   v.srdy = srdy; v.srv = srv; v.srd = srd;
        v.gid = gid; v.bsy = bsy;  v.tmo = tmo;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(input logic g);
        return g ? A1 : A0;
    endfunction

    function automatic logic [31:0] wdata_of(input logic g);
        return g ? 32'h1111_2222 : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [3:0] wstrb_of(input logic g);
        return g ? 4'h3 : 4'hF;
    endfunction

    function automatic logic [1:0] onehot(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    // Drive one cycle of inputs just after the edge, check outputs mid-cycle.
    task automatic run_vec(input string name, input vec_t v);
        @(posedge clk);
        #1;
        rst      = v.rst;
        s_valid  = v.sv;
        s_write  = v.sw;
        m_ready  = v.mr;
        m_rvalid = v.mrv;
        m_rdata  = v.mrd;
        @(negedge clk);
        n_tests++;
        if ({m_valid, m_write, m_addr, s_ready, s_rvalid, s_rdata, grant_id, busy, rd_timeout} !==
            {v.mv, v.mw, v.ma, v.srdy, v.srv, v.srd, v.gid, v.bsy, v.tmo}) begin
            n_fail++;
            $display("FAIL %s: got mv=%0b mw=%0b ma=%h srdy=%b srv=%b srd=%h gid=%0d busy=%0b tmo=%0b; need mv=%0b mw=%0b ma=%h srdy=%b srv=%b srd=%h gid=%0d busy=%0b tmo=%0b",
                     name, m_valid, m_write, m_addr, s_ready, s_rvalid, s_rdata, grant_id, busy, rd_timeout,
                     v.mv, v.mw, v.ma, v.srdy, v.srv, v.srd, v.gid, v.bsy, v.tmo);
        end
        if (v.mv && v.mw) begin
            n_tests++;
            if (m_wdata !== wdata_of(v.gid) || m_wstrb !== wstrb_of(v.gid)) begin
                n_fail++;
                $display("FAIL %s_wfields: got wdata=%h wstrb=%h; need wdata=%h wstrb=%h",
                         name, m_wdata, m_wstrb, wdata_of(v.gid), wstrb_of(v.gid));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g;
        logic prev_g;

        // Single master 0: write, then read back.
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 32'h0,        1, 1, A0,    2'b01, 2'b00, 32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 1, 32'hDEAD_BEEF, 1, 0, A0,   2'b01, 2'b01, 32'hDEAD_BEEF, 0, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        // Master 1 read with a 3-cycle response while master 0 holds a write.
        tbl.push_back(mk(0, 2'b11, 2'b01, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, 0, 32'h0,        1, 0, A1,    2'b10, 2'b00, 32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, 1, 32'hCAFE_F00D, 0, 0, 32'h0, 2'b00, 2'b10, 32'hCAFE_F00D, 1, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 1, 0, 32'h0,        1, 1, A0,    2'b01, 2'b00, 32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        // Master 1 write moves the pointer to 0; master 0 then aborts in ADDR.
        tbl.push_back(mk(0, 2'b10, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b10, 2'b10, 1, 0, 32'h0,        1, 1, A1,    2'b10, 2'b00, 32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 1, 0, 32'h0,        0, 1, A0,    2'b00, 2'b00, 32'h0,        0, 1, 0));
        // Pointer must still favour master 0 after the abort; then master 1 gets its turn.
        tbl.push_back(mk(0, 2'b11, 2'b11, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, 0, 32'h0,        1, 1, A0,    2'b01, 2'b00, 32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 2'b10, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 2'b10, 2'b10, 1, 0, 32'h0,        1, 1, A1,    2'b10, 2'b00, 32'h0,        1, 1, 0));
        // Stray m_rvalid in IDLE is not forwarded.
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 32'h1234_5678, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,        1, 0, 0));

        // Reset: hold two edges, then check a cycle with rst still high.
        repeat (2) @(posedge clk);
        run_vec("reset", mk(1, 2'b11, 2'b11, 1, 1, ERR, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Both masters write continuously: grants alternate 0,1,0,1,...
        prev_g = 1'b1;
        for (int t = 0; t < 8; t++) begin
            g = (t % 2 == 1);
            run_vec($sformatf("rr_idle[%0d]", t),
                    mk(0, 2'b11, 2'b11, 1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, prev_g, 0, 0));
            run_vec($sformatf("rr_addr[%0d]", t),
                    mk(0, 2'b11, 2'b11, 1, 0, 32'h0, 1, 1, addr_of(g), onehot(g), 2'b00, 32'h0, g, 1, 0));
            prev_g = g;
        end
        run_vec("rr_done", mk(0, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, 0));

        // Read that never gets a response: error data on the 16th RDATA cycle.
        run_vec("to_idle", mk(0, 2'b10, 2'b00, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, 0));
        run_vec("to_addr", mk(0, 2'b10, 2'b00, 1, 0, 32'h0, 1, 0, A1, 2'b10, 2'b00, 32'h0, 1, 1, 0));
        for (int k = 0; k < 16; k++) begin
            run_vec($sformatf("to_wait[%0d]", k),
                    mk(0, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00,
                       (k == 15) ? 2'b10 : 2'b00, (k == 15) ? ERR : 32'h0, 1, 1, (k == 15)));
        end
        run_vec("to_late", mk(0, 2'b00, 2'b00, 0, 1, 32'h5555_AAAA, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, 0));
        run_vec("to_next_idle", mk(0, 2'b01, 2'b01, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 0, 0));
        run_vec("to_next_addr", mk(0, 2'b01, 2'b01, 1, 0, 32'h0, 1, 1, A0, 2'b01, 2'b00, 32'h0, 0, 1, 0));

        // Reset while master 1 waits in RDATA.
        run_vec("rst_idle", mk(0, 2'b10, 2'b00, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 0));
        run_vec("rst_addr", mk(0, 2'b10, 2'b00, 1, 0, 32'h0, 1, 0, A1, 2'b10, 2'b00, 32'h0, 1, 1, 0));
        run_vec("rst_rdata", mk(0, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 1, 0));
        run_vec("rst_assert", mk(1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 1, 1, 0));
        run_vec("rst_after", mk(0, 2'b00, 2'b00, 0, 1, 32'h1234_5678, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 0));
        run_vec("rst_ptr_idle", mk(0, 2'b11, 2'b11, 0, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 0, 0));
        run_vec("rst_ptr_addr", mk(0, 2'b11, 2'b11, 1, 0, 32'h0, 1, 1, A0, 2'b01, 2'b00, 32'h0, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_simple_arbiter.md
Name: bus_simple_arbiter

Overview:
- N-master round-robin arbiter sharing the single bus_simple master port of bus_interconnect.
- Typical masters: axi2simple_bridge (CPU/host) and the DMA engine.
- Grant is held for one full transaction: write until accepted; read until m_rvalid or timeout.
- Sits between the masters and bus_interconnect m_*.
- Provides fairness, an address-phase abort path and a read-response timeout.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- RD_TIMEOUT, 256, cycles to wait in RDATA before a forced error response (>=2).
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on read timeout.

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- s_valid  in  NUM_MASTERS  per-master request valid; must be held until s_ready
- s_write  in  NUM_MASTERS  per-master 1=write, 0=read
- s_addr  in  NUM_MASTERS*32  packed, master i at [32i+31:32i]
- s_wdata  in  NUM_MASTERS*32  packed write data
- s_wstrb  in  NUM_MASTERS*4  packed byte strobes
- s_ready  out  NUM_MASTERS  per-master request accept, one-hot or zero
- s_rvalid  out  NUM_MASTERS  per-master read data valid pulse, one-hot or zero
- s_rdata  out  32  shared read data, meaningful only with s_rvalid
- m_valid, m_write  out  1  to interconnect
- m_addr, m_wdata  out  32  to interconnect
- m_wstrb  out  4  to interconnect
- m_ready  in  1  from interconnect
- m_rvalid  in  1  from interconnect
- m_rdata  in  32  from interconnect
- grant_id  out  $clog2(NUM_MASTERS)  current/last granted master
- busy  out  1  state != IDLE
- rd_timeout  out  1  one-cycle pulse when a read times out

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0.
  - All outputs 0.
  - rst mid-transaction aborts immediately, with no s_ready/s_rvalid issued.
- States: IDLE, ADDR, RDATA.
- IDLE:
  - If any s_valid, pick the first requester at or after rr_ptr (wrapping mod NUM_MASTERS).
  - Register the pick into grant_id; go to ADDR.
  - Arbitration latency is 1 cycle; m_valid=0 in IDLE.
- ADDR:
  - m_* = fields of master grant_id; m_valid = s_valid[grant_id].
  - s_ready[grant_id] = m_ready (combinational pass-through).
  - Write handshake (m_valid & m_ready & m_write):
    - go to IDLE; rr_ptr = grant_id+1 (wrap).
  - Read handshake:
    - If m_rvalid in the same cycle: s_rvalid[grant_id]=1, s_rdata=m_rdata, then IDLE with rr_ptr update.
    - Otherwise go to RDATA and clear the counter.
  - s_valid[grant_id] dropped before handshake (protocol abort):
    - go to IDLE; rr_ptr unchanged; no m_valid that cycle.
- RDATA:
  - m_valid=0; other requests wait.
  - On m_rvalid: s_rvalid[grant_id]=1, s_rdata=m_rdata, go to IDLE, rr_ptr update.
  - Else the counter increments.
  - When counter==RD_TIMEOUT-1 without m_rvalid:
    - s_rvalid[grant_id]=1, s_rdata=ERR_RDATA, rd_timeout=1 for one cycle.
    - go to IDLE, rr_ptr update.
  - m_rvalid arriving after a timeout while in IDLE/ADDR-before-read-handshake is ignored; it is not forwarded.
- Fairness: a master finishing a transaction has lowest priority next round.
  - Worst-case wait for an always-requesting master = NUM_MASTERS-1 transactions.
- Back-to-back: minimum 1 IDLE cycle between transactions.
  - Write throughput is 1 per 2 cycles with 0-wait slaves.
- s_ready/s_rvalid are never asserted to non-granted masters.
- Outputs in IDLE/RDATA: m_addr/m_wdata/m_wstrb/m_write may be held at last values, but m_valid=0.

Decomposition:
- snn_soc_pkg gains:
  - BUS_AW=32, BUS_DW=32, BUS_SW=4.
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_RDATA} arb_state_t.
- One sub-module, rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector, ptr. Outputs: gnt_idx, gnt_any.
  - Implementation: double-width rotate plus priority encoder.
  - Unit-testable standalone.

Test Plan:
- Single master 0 write 0x4000_0000 (REG_BASE) data 0xDEAD_BEEF strb F -> m_valid 1 cycle after s_valid; s_ready[0] with m_ready; busy falls next cycle; read back via master 0 gives s_rvalid[0], s_rdata=0xDEAD_BEEF.
- Masters 0 and 1 both hold write requests continuously for 4 transactions each -> grant order 0,1,0,1,...; no starvation; s_ready never on both.
- Read to slave with m_rvalid 3 cycles after m_ready -> state ADDR->RDATA 3 cycles; s_rvalid[1] only; master 0 pending write is not accepted until after.
- Read with m_rvalid never asserted, RD_TIMEOUT=16 -> after 16 RDATA cycles s_rvalid pulse with s_rdata=0xDEAD_BEEF and rd_timeout=1; next request is served normally.
- Master 0 drops s_valid in ADDR before m_ready -> IDLE, rr_ptr unchanged, no s_ready; master 1 request then granted.
- rst asserted in RDATA -> next cycle busy=0, all s_ready/s_rvalid/m_valid=0, grant_id=0; late m_rvalid ignored.
